// File: rtl/pid_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pid_pkg
//  Description : Shared types, default parameters and saturation helpers for
//                the time-multiplexed PID sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package pid_pkg;

    localparam int                PID_WIDTH     = 16;
    localparam int                PID_FRAC      = 8;
    localparam logic signed [15:0] PID_INT_LIMIT = 16'sh3FFF;

    // Wide enough for the sum of three shifted 32-bit products without wrap.
    localparam int ACC_W = 34;

    localparam logic signed [ACC_W-1:0] c_sat_max = 34'sd32767;
    localparam logic signed [ACC_W-1:0] c_sat_min = -34'sd32768;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TERMS = 3'd1,
        S_MUL_P = 3'd2,
        S_MUL_I = 3'd3,
        S_MUL_D = 3'd4,
        S_SUM   = 3'd5,
        S_HOLD  = 3'd6
    } state_t;

    // Clamp a wide signed value into the 16-bit signed range.
    function automatic logic signed [PID_WIDTH-1:0] sat16(input logic signed [ACC_W-1:0] x);
        logic signed [ACC_W-1:0] y;
        if (x > c_sat_max)      y = c_sat_max;
        else if (x < c_sat_min) y = c_sat_min;
        else                    y = x;
        return y[PID_WIDTH-1:0];
    endfunction

    function automatic logic sat16_hit(input logic signed [ACC_W-1:0] x);
        return (x > c_sat_max) || (x < c_sat_min);
    endfunction

    // Symmetric clamp to +/-lim; lim always fits in 16 bits.
    function automatic logic signed [PID_WIDTH-1:0] clamp(input logic signed [ACC_W-1:0] x,
                                                          input logic signed [ACC_W-1:0] lim);
        logic signed [ACC_W-1:0] y;
        if (x > lim)       y = lim;
        else if (x < -lim) y = -lim;
        else               y = x;
        return y[PID_WIDTH-1:0];
    endfunction

    function automatic logic clamp_hit(input logic signed [ACC_W-1:0] x,
                                       input logic signed [ACC_W-1:0] lim);
        return (x > lim) || (x < -lim);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pid_mul_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pid_mul_unit
//  Description : Shared signed WIDTHxWIDTH multiplier. Operands arrive from
//                registers through the sequencer's operand mux; the product is
//                arithmetic-shifted right by FRAC to drop the gain fraction.
//  Revision    : 1.0 - initial release
// ============================================================================
module pid_mul_unit
    import pid_pkg::*;
#(
    parameter int WIDTH = PID_WIDTH,
    parameter int FRAC  = PID_FRAC
) (
    input  logic signed [WIDTH-1:0]   i_a,
    input  logic signed [WIDTH-1:0]   i_b,
    output logic signed [2*WIDTH-1:0] o_p
);

    logic signed [2*WIDTH-1:0] w_full;

    // Full-precision product, then drop the fractional bits with floor rounding.
    always_comb begin
        w_full = (2*WIDTH)'(i_a) * (2*WIDTH)'(i_b);
        o_p    = w_full >>> FRAC;
    end

endmodule
`default_nettype wire

// File: rtl/pid_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pid_sequencer
//  Description : Control sequencer for a 16-bit PID loop. Latches one sample,
//                forms error/integral/derivative, runs the P, I and D products
//                through one multiplier, then saturates and hands the result
//                out over a valid/ready port.
//  Revision    : 1.0 - initial release
// ============================================================================
module pid_sequencer
    import pid_pkg::*;
#(
    parameter int                      WIDTH     = PID_WIDTH,
    parameter int                      FRAC      = PID_FRAC,
    parameter logic signed [WIDTH-1:0] INT_LIMIT = PID_INT_LIMIT
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clear,
    input  logic signed [WIDTH-1:0] setpoint,
    input  logic signed [WIDTH-1:0] measured,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] kp,
    input  logic signed [WIDTH-1:0] ki,
    input  logic signed [WIDTH-1:0] kd,
    output logic signed [WIDTH-1:0] out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    sat
);

    state_t r_state;
    state_t w_next_state;

    logic signed [WIDTH-1:0]   r_error;
    logic signed [WIDTH-1:0]   r_integral;
    logic signed [WIDTH-1:0]   r_prev_error;
    logic signed [WIDTH-1:0]   r_deriv;
    logic signed [WIDTH-1:0]   r_kp;
    logic signed [WIDTH-1:0]   r_ki;
    logic signed [WIDTH-1:0]   r_kd;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [WIDTH-1:0]   r_out;
    logic                      r_sat;
    logic                      r_clamp;    // any clamp seen so far for this sample

    logic signed [ACC_W-1:0]   w_err_wide;
    logic signed [ACC_W-1:0]   w_int_wide;
    logic signed [ACC_W-1:0]   w_der_wide;
    logic signed [ACC_W-1:0]   w_int_lim;
    logic signed [WIDTH-1:0]   w_mul_a;
    logic signed [WIDTH-1:0]   w_mul_b;
    logic signed [2*WIDTH-1:0] w_mul_p;

    // State register; clear aborts any sample in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   r_state <= S_IDLE;
        else if (clear) r_state <= S_IDLE;
        else            r_state <= w_next_state;
    end

    // Next-state sequencing and handshake outputs.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) w_next_state = S_TERMS;
            end
            S_TERMS: w_next_state = S_MUL_P;
            S_MUL_P: w_next_state = S_MUL_I;
            S_MUL_I: w_next_state = S_MUL_D;
            S_MUL_D: w_next_state = S_SUM;
            S_SUM:   w_next_state = S_HOLD;
            S_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Wide intermediates so no subtraction or accumulation can wrap.
    always_comb begin
        w_err_wide = ACC_W'(setpoint) - ACC_W'(measured);
        w_int_wide = ACC_W'(r_integral) + ACC_W'(r_error);
        w_der_wide = ACC_W'(r_error) - ACC_W'(r_prev_error);
        w_int_lim  = ACC_W'(INT_LIMIT);
    end

    // Multiplier operand schedule: kp*error, ki*integral, kd*deriv.
    always_comb begin
        w_mul_a = r_kp;
        w_mul_b = r_error;
        case (r_state)
            S_MUL_I: begin
                w_mul_a = r_ki;
                w_mul_b = r_integral;
            end
            S_MUL_D: begin
                w_mul_a = r_kd;
                w_mul_b = r_deriv;
            end
            default: ;
        endcase
    end

    pid_mul_unit #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_mul (
        .i_a (w_mul_a),
        .i_b (w_mul_b),
        .o_p (w_mul_p)
    );

    // Datapath registers advanced by the current state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_error      <= '0;
            r_integral   <= '0;
            r_prev_error <= '0;
            r_deriv      <= '0;
            r_kp         <= '0;
            r_ki         <= '0;
            r_kd         <= '0;
            r_acc        <= '0;
            r_out        <= '0;
            r_sat        <= 1'b0;
            r_clamp      <= 1'b0;
        end else if (clear) begin
            r_error      <= '0;
            r_integral   <= '0;
            r_prev_error <= '0;
            r_deriv      <= '0;
            r_kp         <= '0;
            r_ki         <= '0;
            r_kd         <= '0;
            r_acc        <= '0;
            r_out        <= '0;
            r_sat        <= 1'b0;
            r_clamp      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_error <= sat16(w_err_wide);
                        r_clamp <= sat16_hit(w_err_wide);
                        r_kp    <= kp;
                        r_ki    <= ki;
                        r_kd    <= kd;
                    end
                end
                S_TERMS: begin
                    r_integral   <= clamp(w_int_wide, w_int_lim);
                    r_deriv      <= sat16(w_der_wide);
                    r_prev_error <= r_error;
                    r_acc        <= '0;
                    r_clamp      <= r_clamp | clamp_hit(w_int_wide, w_int_lim)
                                            | sat16_hit(w_der_wide);
                end
                S_MUL_P, S_MUL_I, S_MUL_D: begin
                    r_acc <= r_acc + ACC_W'(w_mul_p);
                end
                S_SUM: begin
                    r_out <= sat16(r_acc);
                    r_sat <= r_clamp | sat16_hit(r_acc);
                end
                default: ;
            endcase
        end
    end

    assign out = r_out;
    assign sat = r_sat & out_valid;

endmodule
`default_nettype wire

// File: tb/tb_pid_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pid_sequencer
//  Description : Self-checking bench for pid_sequencer. Stimulus pushes the
//                expected result on accept; a monitor pops on each output
//                handshake and also checks latency and HOLD stability.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pid_sequencer;

    logic                clk      = 1'b0;
    logic                reset_n  = 1'b0;
    logic                clear    = 1'b0;
    logic signed [15:0]  setpoint = '0;
    logic signed [15:0]  measured = '0;
    logic signed [15:0]  kp       = '0;
    logic signed [15:0]  ki       = '0;
    logic signed [15:0]  kd       = '0;
    logic                in_valid = 1'b0;
    logic                out_ready = 1'b1;
    logic                in_ready;
    logic signed [15:0]  out;
    logic                out_valid;
    logic                busy;
    logic                sat;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [15:0] val;
        logic        sat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    pid_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .setpoint  (setpoint),
        .measured  (measured),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .kp        (kp),
        .ki        (ki),
        .kd        (kd),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    function automatic void chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endfunction

    function automatic void fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endfunction

    // Monitor: output checks decoupled from stimulus.
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [15:0] last_out   = '0;
    logic        last_sat   = 1'b0;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_valid <= 1'b0;
            prev_ready <= 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                chk1("hold_valid", out_valid, 1'b1);
                chk16("hold_out", out, last_out);
                chk1("hold_sat", sat, last_sat);
            end
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid actual=1 required=0 (no sample pending)");
                end else begin
                    chk16("latency", 16'(cyc - sb[0].acc), 16'd6);
                end
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                chk16("out", out, sb[0].val);
                chk1("sat", sat, sb[0].sat);
                sb.delete(0);
            end
            prev_valid <= out_valid;
            prev_ready <= out_ready;
            last_out   <= out;
            last_sat   <= sat;
        end
    end

    task automatic send(input logic signed [15:0] sp, input logic signed [15:0] m,
                        input logic signed [15:0] gp, input logic signed [15:0] gi,
                        input logic signed [15:0] gd, input logic [15:0] ev,
                        input logic es, input bit expect_out);
        exp_t e;
        int   n;
        @(posedge clk); #1;
        setpoint = sp; measured = m; kp = gp; ki = gi; kd = gd; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            fail_now("accept");
        end else if (expect_out) begin
            e.val = ev; e.sat = es; e.acc = cyc;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        // Scramble inputs: the sample must already be latched.
        in_valid = 1'b0;
        setpoint = 16'sh1357; measured = -16'sh0246;
        kp = 16'sh7FFF; ki = 16'sh7FFF; kd = 16'sh7FFF;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail_now("drain");
    endtask

    task automatic clear_pulse();
        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk16("rst_out", out, 16'h0000);
        chk1("rst_sat", sat, 1'b0);

        // Proportional path, sign handling and floor shift.
        send(16'sd100, 16'sd40, 16'sh0100, 16'sh0000, 16'sh0000, 16'd60, 1'b0, 1'b1);
        send(16'sd40, 16'sd100, 16'sh0100, 16'sh0000, 16'sh0000, 16'hFFC4, 1'b0, 1'b1);
        send(16'sd0, 16'sd3, 16'sh0080, 16'sh0000, 16'sh0000, 16'hFFFE, 1'b0, 1'b1);
        drain();
        clear_pulse();
        @(negedge clk);
        chk1("clr_in_ready", in_ready, 1'b1);
        chk1("clr_busy", busy, 1'b0);
        chk16("clr_out", out, 16'h0000);

        // Integral accumulation, then clear restarts it.
        send(16'sd10, 16'sd0, 16'sh0000, 16'sh0080, 16'sh0000, 16'd5, 1'b0, 1'b1);
        send(16'sd10, 16'sd0, 16'sh0000, 16'sh0080, 16'sh0000, 16'd10, 1'b0, 1'b1);
        drain();
        clear_pulse();
        send(16'sd10, 16'sd0, 16'sh0000, 16'sh0080, 16'sh0000, 16'd5, 1'b0, 1'b1);
        drain();

        // Derivative after a reset: prev_error starts at zero.
        @(posedge clk); #1 reset_n = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        send(16'sd10, 16'sd0, 16'sh0000, 16'sh0000, 16'sh0100, 16'd10, 1'b0, 1'b1);
        send(16'sd30, 16'sd0, 16'sh0000, 16'sh0000, 16'sh0100, 16'd20, 1'b0, 1'b1);
        drain();

        // Saturation of error/output, integral pinned at the limit.
        clear_pulse();
        send(16'sh7FFF, -16'sh8000, 16'sh0200, 16'sh0000, 16'sh0000, 16'h7FFF, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++)
            send(16'sh7FFF, -16'sh8000, 16'sh0000, 16'sh0100, 16'sh0000, 16'h3FFF, 1'b1, 1'b1);
        send(-16'sh8000, 16'sh7FFF, 16'sh0100, 16'sh0000, 16'sh0000, 16'h8000, 1'b1, 1'b1);
        drain();

        // Backpressure in HOLD.
        clear_pulse();
        out_ready = 1'b0;
        send(16'sd5, 16'sd0, 16'sh0100, 16'sh0000, 16'sh0000, 16'd5, 1'b0, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) fail_now("bp_valid");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; setpoint = 16'sd1000; kp = 16'sh0100;
            @(negedge clk);
            chk1("bp_in_ready", in_ready, 1'b0);
            chk1("bp_out_valid", out_valid, 1'b1);
            chk16("bp_out", out, 16'd5);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk1("bp_release_valid", out_valid, 1'b0);
        chk1("bp_release_ready", in_ready, 1'b1);

        // Abort by clear during MUL_I.
        send(16'sd50, 16'sd0, 16'sh0100, 16'sh0100, 16'sh0000, 16'd0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        @(negedge clk);
        chk1("abort_clr_in_ready", in_ready, 1'b1);
        chk1("abort_clr_busy", busy, 1'b0);
        chk16("abort_clr_out", out, 16'h0000);
        repeat (8) @(negedge clk);
        send(16'sd20, 16'sd0, 16'sh0000, 16'sh0100, 16'sh0100, 16'd40, 1'b0, 1'b1);
        drain();

        // Abort by asynchronous reset mid-cycle.
        send(16'sd50, 16'sd0, 16'sh0100, 16'sh0100, 16'sh0000, 16'd0, 1'b0, 1'b0);
        @(posedge clk); #3 reset_n = 1'b0;
        #1;
        chk1("abort_rst_in_ready", in_ready, 1'b1);
        chk1("abort_rst_busy", busy, 1'b0);
        chk1("abort_rst_valid", out_valid, 1'b0);
        chk16("abort_rst_out", out, 16'h0000);
        @(negedge clk); #1 reset_n = 1'b1;
        repeat (8) @(negedge clk);
        send(16'sd20, 16'sd0, 16'sh0000, 16'sh0100, 16'sh0100, 16'd40, 1'b0, 1'b1);
        drain();

        chk16("scoreboard_empty", 16'(sb.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pid_sequencer.md
Name: pid_sequencer

Overview:
- Time-multiplexed control sequencer for the 16-bit PID datapath.
- Accepts one (setpoint, measured) sample per handshake and computes error, integral and derivative terms.
- Schedules a single shared 16x16 signed multiplier across the P, I and D products, then sums, saturates and presents the result on a valid/ready output.
- Owns the synchronous clear that zeroes the datapath registers (integral, previous error, output).

Parameters:
- WIDTH, 16, data width of setpoint, measured, gains and output (signed two's complement).
- FRAC, 8, fractional bits of the gains (Q8.8); products are arithmetic-shifted right by FRAC.
- INT_LIMIT, 16'sh3FFF, symmetric clamp on the integral accumulator (+/-INT_LIMIT).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous clear of all datapath state; aborts any sample in flight.
- setpoint  input  WIDTH  signed target.
- measured  input  WIDTH  signed plant measurement.
- in_valid  input  1  sample present.
- in_ready  output  1  sequencer can accept a sample.
- kp, ki, kd  input  WIDTH each  signed Q8.8 gains.
- out  output  WIDTH  signed saturated controller output.
- out_valid  output  1  out holds a fresh result.
- out_ready  input  1  consumer accepts out.
- busy  output  1  high in any state other than IDLE.
- sat  output  1  high with out_valid if any clamp fired for this sample.

Behaviour:
- Reset (reset_n low, asynchronous) values:
  - state = IDLE, in_ready = 1.
  - out = 0, out_valid = 0, busy = 0, sat = 0.
  - integral = 0, prev_error = 0.
- clear (synchronous, priority over all other activity):
  - Same values as reset on the next edge, with in_ready = 1 the following cycle.
  - The in-flight sample is discarded; out_valid never rises for it.
- States: IDLE -> TERMS -> MUL_P -> MUL_I -> MUL_D -> SUM -> HOLD -> IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready (cycle T):
    - Latch error = sat16(setpoint - measured), computed in 17 bits.
    - Latch kp, ki, kd. Gain changes after T do not affect this sample.
- TERMS (T+1):
  - integral <= clamp(integral + error, +/-INT_LIMIT), computed in 17 bits.
  - deriv <= sat16(error - prev_error).
  - prev_error <= error.
- MUL_P, MUL_I, MUL_D (T+2..T+4):
  - One multiplier use per cycle: kp*error, ki*integral (new value), kd*deriv.
  - Each 32-bit product is arithmetic-shifted right by FRAC.
  - Results are accumulated in a 34-bit signed accumulator; the accumulator is cleared in TERMS.
- SUM (T+5):
  - out <= sat16(acc).
  - sat <= OR of all clamps fired this sample (error, integral, deriv, output).
- HOLD (from T+6):
  - out_valid = 1; out and sat held stable.
  - On out_ready, state returns to IDLE and out_valid drops on the next edge.
  - Latency from accept to out_valid is 6 cycles.
  - Throughput is one sample per 7 cycles with out_ready held high.
- Handshake rules:
  - in_ready = 0 outside IDLE; no input is buffered.
  - out_valid must not drop without out_ready.
  - out keeps its last value after the handshake until the next SUM.
- Saturation:
  - sat16 clamps to [-32768, 32767].
  - The integral clamp prevents wind-up; no wrap-around is permitted anywhere.
- Simultaneous events:
  - clear with in_valid: clear wins and the sample is not accepted.
  - clear with out_ready in HOLD: clear wins.
- Reset mid-operation: immediate return to reset values, regardless of clk.

Decomposition:
- Package pid_pkg holds:
  - the state enum;
  - WIDTH/FRAC defaults;
  - the sat16 and clamp functions;
  - INT_LIMIT default.
- Sub-module pid_mul_unit: registered-input signed 16x16 multiplier with FRAC shift. It is the shared resource the FSM schedules; it is purely combinational after its operand mux.

Test Plan:
- P-only: kp=0x0100, ki=kd=0, setpoint=100, measured=40 -> out=60, sat=0, out_valid exactly 6 cycles after accept.
- I accumulation: kp=kd=0, ki=0x0080, two samples with error=10 -> outputs 5 then 10. Then clear -> the next error=10 sample gives 5.
- D term: kp=ki=0, kd=0x0100, errors 10 then 30 -> outputs 10 then 20. prev_error after reset = 0.
- Saturation: setpoint=0x7FFF, measured=0x8000, kp=0x0200 -> error clamps to 0x7FFF, out=0x7FFF, sat=1. Also check that integral stays at INT_LIMIT over 5 samples.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD -> out, sat and out_valid stable, in_ready=0, in_valid ignored. out_ready=1 -> IDLE next cycle.
- Abort: clear asserted during MUL_I, and separately reset_n pulsed low mid-cycle -> out_valid never rises, integral=prev_error=0, in_ready=1 next cycle, next sample computes correctly.
